// File: rtl/nwr_req_packer_pkg.sv
// Shared constants, state encoding and segment-size helpers for the
// NWRITE request packer.
package nwr_req_packer_pkg;

  localparam int          DEF_MAX_BYTES = 256;
  localparam logic [1:0]  DEF_PRIO      = 2'b01;
  localparam logic [15:0] DEF_SRC_ID    = 16'h00FF;
  localparam logic [15:0] DEF_DEST_ID   = 16'h00AA;

  localparam logic [3:0] HELLO_FTYPE_NWRITE = 4'h5;
  localparam logic [3:0] HELLO_TTYPE_NWRITE = 4'h4;

  // HELLO header field positions (LSB of each field)
  localparam int HDR_TID_LSB   = 56;
  localparam int HDR_FTYPE_LSB = 52;
  localparam int HDR_TTYPE_LSB = 48;
  localparam int HDR_PRIO_LSB  = 45;
  localparam int HDR_SIZE_LSB  = 36;
  localparam int HDR_ADDR_LSB  = 0;

  localparam int ADDR_W  = 34;
  localparam int REM_W   = 13;
  localparam int SEG_W   = 9;
  localparam int SBEAT_W = 6;
  localparam int XBEAT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [SEG_W-1:0] seg_bytes_f(input logic [REM_W-1:0] rem,
                                                  input int max_bytes);
    if (rem > REM_W'(max_bytes)) return SEG_W'(max_bytes);
    return rem[SEG_W-1:0];
  endfunction

  function automatic logic [SBEAT_W-1:0] seg_beats_f(input logic [SEG_W-1:0] seg);
    logic [SEG_W:0] t;
    t = {1'b0, seg} + (SEG_W+1)'(7);
    return SBEAT_W'(t >> 3);
  endfunction

  function automatic logic [XBEAT_W-1:0] xfer_beats_f(input logic [REM_W-1:0] nbytes);
    logic [REM_W:0] t;
    t = {1'b0, nbytes} + (REM_W+1)'(7);
    return XBEAT_W'(t >> 3);
  endfunction

endpackage

// File: rtl/nwr_req_packer_if.sv
// User NWRITE data stream and SRIO ireq AXI4-Stream bundle.
// slave = packer side, master = generator/core (testbench) side.
interface nwr_req_packer_if;
  logic [33:0] user_addr_i;
  logic [11:0] user_tsize_i;
  logic [63:0] user_tdata_i;
  logic        user_tvalid_i;
  logic [7:0]  user_tkeep_i;
  logic        user_tlast_i;
  logic        user_tready_o;
  logic [63:0] ireq_tdata_o;
  logic        ireq_tvalid_o;
  logic [7:0]  ireq_tkeep_o;
  logic        ireq_tlast_o;
  logic [31:0] ireq_tuser_o;
  logic        ireq_tready_i;

  modport slave (
    input  user_addr_i, user_tsize_i, user_tdata_i, user_tvalid_i,
           user_tkeep_i, user_tlast_i, ireq_tready_i,
    output user_tready_o, ireq_tdata_o, ireq_tvalid_o, ireq_tkeep_o,
           ireq_tlast_o, ireq_tuser_o
  );

  modport master (
    output user_addr_i, user_tsize_i, user_tdata_i, user_tvalid_i,
           user_tkeep_i, user_tlast_i, ireq_tready_i,
    input  user_tready_o, ireq_tdata_o, ireq_tvalid_o, ireq_tkeep_o,
           ireq_tlast_o, ireq_tuser_o
  );
endinterface

// File: rtl/nwr_req_packer_hdr.sv
// Combinational HELLO NWRITE header assembly.
module nwr_req_packer_hdr
  import nwr_req_packer_pkg::*;
(
  input  logic [7:0]        i_tid,
  input  logic [1:0]        i_prio,
  input  logic [7:0]        i_size_m1,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [63:0]       o_hdr
);

  always_comb begin
    o_hdr = '0;
    o_hdr[HDR_TID_LSB   +: 8]      = i_tid;
    o_hdr[HDR_FTYPE_LSB +: 4]      = HELLO_FTYPE_NWRITE;
    o_hdr[HDR_TTYPE_LSB +: 4]      = HELLO_TTYPE_NWRITE;
    o_hdr[HDR_PRIO_LSB  +: 2]      = i_prio;
    o_hdr[HDR_SIZE_LSB  +: 8]      = i_size_m1;
    o_hdr[HDR_ADDR_LSB  +: ADDR_W] = i_addr;
  end

endmodule

// File: rtl/nwr_req_packer.sv
// Packs the user NWRITE stream into HELLO NWRITE packets on ireq, splitting
// transfers into MAX_BYTES segments with incrementing address and tid.
module nwr_req_packer
  import nwr_req_packer_pkg::*;
#(
  parameter int          MAX_BYTES = DEF_MAX_BYTES,
  parameter logic [1:0]  PRIO      = DEF_PRIO,
  parameter logic [15:0] SRC_ID    = DEF_SRC_ID,
  parameter logic [15:0] DEST_ID   = DEF_DEST_ID
) (
  input  logic            log_clk,
  input  logic            log_rst,
  nwr_req_packer_if.slave bus,
  output logic            nwr_ready_o,
  output logic            nwr_busy_o,
  output logic            nwr_done_o,
  output logic            err_o,
  output state_t          dbg_state_o
);

  // Handshakes: a beat moves on the rising edge where valid and ready are
  // both high; valid never waits on ready, and a stalled ireq beat holds data.

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [REM_W-1:0]    r_rem;
  logic [7:0]          r_tid;
  logic                r_err;
  logic [63:0]         r_hold;
  logic                r_hold_vld;
  logic [SBEAT_W-1:0]  r_load_left;
  logic [XBEAT_W-1:0]  r_user_left;
  logic [63:0]         r_tdata;
  logic                r_tvalid;
  logic                r_tlast;

  logic                w_out_acc;
  logic                w_out_free;
  logic                w_start;
  logic [SEG_W-1:0]    w_cur_seg;
  logic [REM_W-1:0]    w_rem_after;
  logic                w_seg_end;
  logic                w_next_hdr;
  logic                w_pl_slot;
  logic                w_user_take;
  logic                w_pl_load;
  logic [REM_W-1:0]    w_start_rem;
  logic [REM_W-1:0]    w_hdr_rem;
  logic [SEG_W-1:0]    w_hdr_seg;
  logic [SBEAT_W-1:0]  w_hdr_beats;
  logic [7:0]          w_hdr_tid;
  logic [ADDR_W-1:0]   w_hdr_addr;
  logic [7:0]          w_hdr_size_m1;
  logic [63:0]         w_hdr;
  logic [XBEAT_W-1:0]  w_xfer_beats;
  logic                w_user_acc;
  logic                w_user_last;

  assign w_out_acc   = r_tvalid & bus.ireq_tready_i;
  assign w_out_free  = ~r_tvalid | bus.ireq_tready_i;
  assign w_start     = (r_state == ST_IDLE) & bus.user_tvalid_i;
  assign w_cur_seg   = seg_bytes_f(r_rem, MAX_BYTES);
  assign w_rem_after = r_rem - {{(REM_W-SEG_W){1'b0}}, w_cur_seg};
  assign w_seg_end   = (r_state == ST_PAYLOAD) & w_out_acc & r_tlast;
  assign w_next_hdr  = w_seg_end & (w_rem_after != '0);

  // A payload slot opens when the output register frees up; in HDR that is
  // the header handshake itself, so the next packet runs without a bubble.
  assign w_pl_slot   = (((r_state == ST_PAYLOAD) & w_out_free) |
                        ((r_state == ST_HDR) & w_out_acc)) & (r_load_left != '0);
  assign w_user_take = w_pl_slot & ~r_hold_vld & bus.user_tvalid_i;
  assign w_pl_load   = w_pl_slot & (r_hold_vld | bus.user_tvalid_i);

  assign w_start_rem   = {1'b0, bus.user_tsize_i} + REM_W'(1);
  assign w_hdr_rem     = (r_state == ST_IDLE) ? w_start_rem : w_rem_after;
  assign w_hdr_seg     = seg_bytes_f(w_hdr_rem, MAX_BYTES);
  assign w_hdr_beats   = seg_beats_f(w_hdr_seg);
  assign w_hdr_tid     = (r_state == ST_IDLE) ? r_tid : r_tid + 8'd1;
  assign w_hdr_addr    = (r_state == ST_IDLE) ? bus.user_addr_i
                                              : r_addr + ADDR_W'(MAX_BYTES);
  assign w_hdr_size_m1 = 8'(w_hdr_seg - SEG_W'(1));
  assign w_xfer_beats  = xfer_beats_f(w_start_rem);

  assign w_user_acc  = w_start | w_user_take;
  assign w_user_last = (r_state == ST_IDLE) ? (w_xfer_beats == XBEAT_W'(1))
                                            : (r_user_left == XBEAT_W'(1));

  nwr_req_packer_hdr u_hdr (
    .i_tid     (w_hdr_tid),
    .i_prio    (PRIO),
    .i_size_m1 (w_hdr_size_m1),
    .i_addr    (w_hdr_addr),
    .o_hdr     (w_hdr)
  );

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    nwr_ready_o  = 1'b0;
    nwr_busy_o   = 1'b1;
    nwr_done_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        nwr_ready_o = 1'b1;
        nwr_busy_o  = 1'b0;
        if (bus.user_tvalid_i) w_next_state = ST_HDR;
      end
      ST_HDR: begin
        if (w_out_acc) w_next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_seg_end) w_next_state = (w_rem_after == '0) ? ST_DONE : ST_HDR;
      end
      ST_DONE: begin
        nwr_done_o   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: segment address/remaining bytes, tid, beat counters.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_tid       <= '0;
      r_load_left <= '0;
      r_user_left <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_load_left <= '0;
      r_user_left <= '0;
      r_hold_vld  <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= bus.user_addr_i;
        r_rem       <= w_start_rem;
        r_load_left <= w_hdr_beats;
        r_user_left <= w_xfer_beats - XBEAT_W'(1);
        r_hold      <= bus.user_tdata_i;
        r_hold_vld  <= 1'b1;
      end else begin
        if (w_seg_end) begin
          r_addr <= r_addr + ADDR_W'(MAX_BYTES);
          r_rem  <= w_rem_after;
          r_tid  <= r_tid + 8'd1;
        end
        if (w_next_hdr)     r_load_left <= w_hdr_beats;
        else if (w_pl_load) r_load_left <= r_load_left - SBEAT_W'(1);
        if (w_user_take)    r_user_left <= r_user_left - XBEAT_W'(1);
        if (w_pl_load && r_hold_vld) r_hold_vld <= 1'b0;
      end
    end
  end

  // The length from user_tsize_i is authoritative; tlast is only audited.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst)                                          r_err <= 1'b0;
    else if (w_user_acc && (bus.user_tlast_i != w_user_last)) r_err <= 1'b1;
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_start || w_next_hdr) begin
      r_tdata  <= w_hdr;
      r_tvalid <= 1'b1;
      r_tlast  <= 1'b0;
    end else if (w_pl_load) begin
      r_tdata  <= r_hold_vld ? r_hold : bus.user_tdata_i;
      r_tvalid <= 1'b1;
      r_tlast  <= (r_load_left == SBEAT_W'(1));
    end else if (w_out_acc) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign bus.user_tready_o = (r_state == ST_IDLE) | (w_pl_slot & ~r_hold_vld);
  assign bus.ireq_tdata_o  = r_tdata;
  assign bus.ireq_tvalid_o = r_tvalid;
  assign bus.ireq_tlast_o  = r_tlast;
  assign bus.ireq_tkeep_o  = 8'hFF;
  assign bus.ireq_tuser_o  = {SRC_ID, DEST_ID};
  assign err_o             = r_err;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_nwr_req_packer.sv
// Randomized self-checking bench for nwr_req_packer against a packet-level
// reference model of the NWRITE segmentation rules.
module tb_nwr_req_packer;
  import nwr_req_packer_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic   log_clk;
  logic   log_rst;
  logic   nwr_ready, nwr_busy, nwr_done, err;
  state_t dbg_state;

  nwr_req_packer_if bus ();

  nwr_req_packer dut (
    .log_clk     (log_clk),
    .log_rst     (log_rst),
    .bus         (bus),
    .nwr_ready_o (nwr_ready),
    .nwr_busy_o  (nwr_busy),
    .nwr_done_o  (nwr_done),
    .err_o       (err),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_tid = 0;
  int drv_timeout = 0;
  int first_acc_cyc = 0;
  int stall_bad = 0;
  int side_bad = 0;
  int rdy_mode = 0;
  logic [64:0] exp_q[$];
  beat_t       obs_q[$];
  int          done_q[$];

  // clock / reset
  initial log_clk = 1'b0;
  always #5 log_clk = ~log_clk;
  always @(posedge log_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // core-side ready pattern: 0 always high, 1 toggle, 2 random
  initial begin
    bus.ireq_tready_i = 1'b1;
    forever begin
      @(posedge log_clk);
      #1;
      case (rdy_mode)
        1:       bus.ireq_tready_i = ~bus.ireq_tready_i;
        2:       bus.ireq_tready_i = 1'($urandom_range(0, 1));
        default: bus.ireq_tready_i = 1'b1;
      endcase
    end
  end

  // observer: records ireq handshakes, done pulses and stall stability
  initial begin : monitor
    logic [63:0] st_data;
    logic        st_last;
    bit          stalled;
    stalled = 0;
    forever begin
      @(negedge log_clk);
      if (log_rst) begin
        stalled = 0;
      end else begin
        if (stalled && !(bus.ireq_tvalid_o === 1'b1 && bus.ireq_tdata_o === st_data &&
                         bus.ireq_tlast_o === st_last))
          stall_bad++;
        stalled = bus.ireq_tvalid_o && !bus.ireq_tready_i;
        st_data = bus.ireq_tdata_o;
        st_last = bus.ireq_tlast_o;
        if (bus.ireq_tvalid_o && bus.ireq_tready_i) begin
          obs_q.push_back('{data: bus.ireq_tdata_o, last: bus.ireq_tlast_o, cyc: cyc});
          if (bus.ireq_tkeep_o !== 8'hFF || bus.ireq_tuser_o !== 32'h00FF00AA) side_bad++;
        end
        if (nwr_done) done_q.push_back(cyc);
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
  endtask

  // Driver plus reference model: expected packets come from the byte count
  // split into 256-byte segments, each led by its header.
  task automatic run_xfer(input logic [33:0] addr, input logic [11:0] tsize, input int bad_last);
    logic [63:0] dq[$];
    logic [33:0] a;
    int nb, rem, seg, segb, bi, n, d0;
    nb = (int'(tsize) + 8) / 8;
    for (int i = 0; i < nb; i++) dq.push_back({$urandom, $urandom});
    rem = int'(tsize) + 1;
    a   = addr;
    bi  = 0;
    while (rem > 0) begin
      seg  = (rem > 256) ? 256 : rem;
      segb = (seg + 7) / 8;
      exp_q.push_back({1'b0, 8'(model_tid), 4'h5, 4'h4, 1'b0, 2'b01, 1'b0,
                       8'(seg - 1), 2'b00, a});
      for (int j = 0; j < segb; j++) begin
        exp_q.push_back({(j == segb - 1) ? 1'b1 : 1'b0, dq[bi]});
        bi++;
      end
      rem      -= seg;
      a        += 34'd256;
      model_tid = (model_tid + 1) % 256;
    end
    d0 = done_q.size();
    bus.user_addr_i  = addr;
    bus.user_tsize_i = tsize;
    for (int i = 0; i < nb; i++) begin
      bus.user_tdata_i  = dq[i];
      bus.user_tkeep_i  = 8'($urandom);
      bus.user_tlast_i  = (bad_last >= 0) ? (i == bad_last) : (i == nb - 1);
      bus.user_tvalid_i = 1'b1;
      n = 0;
      @(negedge log_clk);
      while (!bus.user_tready_o && n < 2000) begin
        @(negedge log_clk);
        n++;
      end
      if (n >= 2000) begin
        drv_timeout++;
        break;
      end
      if (i == 0) first_acc_cyc = cyc;
      @(posedge log_clk);
      #1;
    end
    bus.user_tvalid_i = 1'b0;
    bus.user_tlast_i  = 1'b0;
    n = 0;
    while (done_q.size() == d0 && n < 3000) begin
      @(negedge log_clk);
      n++;
    end
    if (done_q.size() == d0) drv_timeout++;
    @(posedge log_clk);
    #1;
  endtask

  task automatic test_reset();
    log_rst = 1'b1;
    repeat (3) @(posedge log_clk);
    @(negedge log_clk);
    checks++; if (bus.ireq_tvalid_o !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", bus.ireq_tvalid_o); end
    checks++; if (bus.ireq_tlast_o !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", bus.ireq_tlast_o); end
    checks++; if (bus.ireq_tdata_o !== 64'd0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", bus.ireq_tdata_o); end
    checks++; if (nwr_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", nwr_done); end
    checks++; if (nwr_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", nwr_busy); end
    checks++; if (nwr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", nwr_ready); end
    checks++; if (bus.user_tready_o !== 1'b1) begin failures++; $display("FAIL rst_utready got=%b exp=1", bus.user_tready_o); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    @(posedge log_clk);
    #1;
    log_rst   = 1'b0;
    model_tid = 0;
    repeat (2) @(posedge log_clk);
    #1;
  endtask

  task automatic test_single();
    clear_queues();
    rdy_mode = 0;
    run_xfer(34'h100, 12'd127, -1);
    checks++; if (obs_q.size() !== 17) begin failures++; $display("FAIL single_count got=%0d exp=17", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        failures++; $display("FAIL single_beat%0d got=%h exp=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
    checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL single_done_cnt got=%0d exp=1", done_q.size()); end
    if (obs_q.size() == 17 && done_q.size() == 1) begin
      checks++; if (obs_q[0].cyc !== first_acc_cyc + 1) begin failures++; $display("FAIL single_hdr_lat got=%0d exp=%0d", obs_q[0].cyc, first_acc_cyc + 1); end
      checks++; if (obs_q[16].cyc - obs_q[0].cyc !== 16) begin failures++; $display("FAIL single_span got=%0d exp=16", obs_q[16].cyc - obs_q[0].cyc); end
      checks++; if (done_q[0] !== obs_q[16].cyc + 1) begin failures++; $display("FAIL single_done_time got=%0d exp=%0d", done_q[0], obs_q[16].cyc + 1); end
    end
    checks++; if (drv_timeout !== 0) begin failures++; $display("FAIL single_timeout got=%0d exp=0", drv_timeout); end
  endtask

  task automatic test_multi_seg();
    logic [11:0] sizes[2];
    logic [33:0] addrs[2];
    sizes[0] = 12'd511;
    sizes[1] = 12'd263;
    addrs[0] = 34'h0;
    addrs[1] = {2'b10, $urandom_range(0, 32'h00FF_FFFF), 8'h00};
    rdy_mode = 0;
    for (int t = 0; t < 2; t++) begin
      clear_queues();
      run_xfer(addrs[t], sizes[t], -1);
      checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL multi%0d_count got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
          failures++; $display("FAIL multi%0d_beat%0d got=%h exp=%h", t, i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
        end
      end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL multi%0d_done_cnt got=%0d exp=1", t, done_q.size()); end
      if (obs_q.size() == exp_q.size() && obs_q.size() > 0) begin
        checks++;
        if (obs_q[obs_q.size()-1].cyc - obs_q[0].cyc !== obs_q.size() - 1) begin
          failures++; $display("FAIL multi%0d_span got=%0d exp=%0d", t, obs_q[obs_q.size()-1].cyc - obs_q[0].cyc, obs_q.size() - 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    stall_bad = 0;
    rdy_mode  = 1;
    run_xfer({2'b01, $urandom}, 12'd127, -1);
    rdy_mode = 2;
    for (int t = 0; t < 4; t++)
      run_xfer({2'(t), $urandom}, 12'($urandom_range(0, 1100)), -1);
    rdy_mode = 0;
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        failures++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
    checks++; if (done_q.size() !== 5) begin failures++; $display("FAIL b2b_done_cnt got=%0d exp=5", done_q.size()); end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL b2b_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (side_bad !== 0) begin failures++; $display("FAIL b2b_keep_tuser got=%0d exp=0", side_bad); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err); end
    checks++; if (drv_timeout !== 0) begin failures++; $display("FAIL b2b_timeout got=%0d exp=0", drv_timeout); end
  endtask

  task automatic test_err();
    clear_queues();
    rdy_mode = 0;
    run_xfer(34'h440, 12'd127, 2);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    checks++; if (obs_q.size() !== 17) begin failures++; $display("FAIL err_count got=%0d exp=17", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        failures++; $display("FAIL err_beat%0d got=%h exp=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
    run_xfer(34'h880, 12'd15, -1);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_queues();
    rdy_mode = 0;
    bus.user_addr_i  = 34'h200;
    bus.user_tsize_i = 12'd511;
    for (int i = 0; i < 10; i++) begin
      bus.user_tdata_i  = {$urandom, $urandom};
      bus.user_tlast_i  = 1'b0;
      bus.user_tvalid_i = 1'b1;
      n = 0;
      @(negedge log_clk);
      while (!bus.user_tready_o && n < 2000) begin
        @(negedge log_clk);
        n++;
      end
      if (n >= 2000) drv_timeout++;
      @(posedge log_clk);
      #1;
    end
    checks++; if (dbg_state !== ST_PAYLOAD) begin failures++; $display("FAIL rmid_state got=%0d exp=%0d", dbg_state, ST_PAYLOAD); end
    log_rst = 1'b1;
    #1;
    checks++; if (bus.ireq_tvalid_o !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", bus.ireq_tvalid_o); end
    checks++; if (nwr_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", nwr_ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", err); end
    bus.user_tvalid_i = 1'b0;
    repeat (2) @(posedge log_clk);
    #1;
    log_rst   = 1'b0;
    model_tid = 0;
    @(posedge log_clk);
    #1;
    clear_queues();
    run_xfer(34'h3_0000_0040, 12'd63, -1);
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        failures++; $display("FAIL rmid_beat%0d got=%h exp=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
    checks++; if (drv_timeout !== 0) begin failures++; $display("FAIL rmid_timeout got=%0d exp=0", drv_timeout); end
  endtask

  initial begin
    bus.user_addr_i   = '0;
    bus.user_tsize_i  = '0;
    bus.user_tdata_i  = '0;
    bus.user_tvalid_i = 1'b0;
    bus.user_tkeep_i  = 8'hFF;
    bus.user_tlast_i  = 1'b0;
    test_reset();
    test_single();
    test_multi_seg();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
